mux4_scan_ctrl: RTL
===================

# mux4_scan_ctrl

Round-robin scan controller that sits directly upstream of the 4:1 12-bit channel mux. It drives the mux select, waits one cycle for the mux output to settle, and captures it. It then presents the sample with its channel index on a valid/ready output. Channels are selectable per scan through a 4-bit enable mask.

## Interface
- WIDTH, 12, data width of each mux input and of the captured sample.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  scan enable; level-sensitive.
- mask  in  4  channel enable, bit i = channel i; sampled only when the next channel is chosen.
- s  out  2  registered select, wired to the mux `s`.
- y  in  WIDTH  mux output (`y` of the mux).
- out_data  out  WIDTH  captured sample.
- out_ch  out  2  channel index of out_data.
- out_valid  out  1  sample available.
- out_ready  in  1  downstream accept.
- scan_done  out  1  one-cycle pulse when the last enabled channel of a pass is accepted.
- busy  out  1  high in any state other than IDLE.

## Operation
- Internal pointer `ptr` (2 bits) holds the channel at which the next search starts.
- Next-channel search: the first index c in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with mask[c]=1.
- FSM states are IDLE, SETTLE and OUT.
- IDLE:
  - If en=1 and mask!=0: s <= search result; go to SETTLE.
  - Otherwise stay in IDLE; s holds its value.
- SETTLE (exactly one cycle):
  - out_data <= y, out_ch <= s, out_valid <= 1; go to OUT.
- OUT:
  - Hold out_data, out_ch and out_valid while out_ready=0. s is stable throughout.
  - On out_valid && out_ready:
    - ptr <= s+1 (mod 4, so 3 wraps to 0).
    - scan_done pulses when mask has no set bit above s. Use the current mask.
    - If en=1 and mask!=0: search from s+1, drive s, out_valid <= 0, go to SETTLE.
    - Otherwise: out_valid <= 0, go to IDLE.
- en deasserted mid-transfer: the current sample still completes through the handshake, then the FSM returns to IDLE. No sample is ever dropped or truncated.
- A mask change while in SETTLE or OUT has no effect on the current sample. It takes effect at the next search.
- A mask containing a single enabled channel re-samples that channel repeatedly.
- scan_done is registered and is 0 at all other times.
- busy = (state != IDLE).

## Timing
- Reset values: s=0, ptr=0, out_data=0, out_ch=0, out_valid=0, scan_done=0, busy=0, state IDLE.
- Reset is asynchronous. Asserting rst_n mid-operation clears everything immediately, including a pending out_valid.
- Latency:
  - en rises before edge N: s is valid after N.
  - y is captured at N+1.
  - out_valid is high after N+1.
- Throughput with out_ready held at 1: one sample every 2 cycles. out_valid is high for 1 cycle in every 2.
- out_valid never drops without a handshake, and out_data/out_ch never change while out_valid=1 and out_ready=0.
- The mux is combinational. s is held constant from SETTLE entry through capture, which guarantees one full cycle of settle time.

## Test plan
Bench models the mux with d0=12'h000, d1=12'h555, d2=12'hAAA, d3=12'hFFF.
- Reset then idle: rst_n=0 for 2 cycles, then 1 with en=0 -> all outputs 0, busy=0, s=0 for 10 cycles.
- Full scan: mask=4'b1111, en=1, out_ready=1 -> (out_ch, out_data) = (0,000), (1,555), (2,AAA), (3,FFF), (0,000), with one sample every 2 cycles; scan_done pulses on acceptance of ch3.
- Sparse mask and wrap: mask=4'b1010 -> ch1=555, ch3=FFF, ch1=555; scan_done after each ch3; ch0 and ch2 never appear.
- Backpressure: out_ready=0 for 5 cycles during ch2 -> out_valid=1, out_data=AAA, out_ch=2 and s=2 stable for all 5 cycles; the next sample is ch3 two cycles after out_ready=1.
- en drop and mask=0: deassert en while in OUT for ch1 -> ch1 is still delivered on handshake, then busy=0. With en=1 and mask=0 -> stays in IDLE, out_valid=0.
- Async reset mid-transfer: rst_n=0 between clock edges while out_valid=1 -> out_valid, out_data, s and busy go to 0 before the next edge; after release the scan restarts at ch0.

Source files
------------

// File: rtl/mux4_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mux4_scan_ctrl
// Description : Round-robin scan controller for a 4:1 channel mux. It drives
//               the mux select, allows one cycle of settle time, captures the
//               mux output and presents it with its channel index on a
//               valid/ready interface. A 4-bit mask selects the channels that
//               take part in each pass.
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_scan_ctrl #(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [3:0]       mask,
   output logic [1:0]       s,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_ch,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             scan_done,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_OUT    = 2'd2
   } state_t;

   state_t           r_state;
   logic [1:0]       r_ptr;
   logic [1:0]       r_s;
   logic [WIDTH-1:0] r_data;
   logic [1:0]       r_ch;
   logic             r_valid;
   logic             r_done;

   logic             w_can_scan;
   logic             w_handshake;
   logic [1:0]       w_s_inc;
   logic [1:0]       w_pick_ptr;
   logic [1:0]       w_pick_next;
   logic [3:0]       w_above;
   logic             w_last;

   // First enabled channel found by walking start, start+1, ... (mod 4).
   // Walking from the far end lets the nearest hit win. An empty mask yields
   // the start index, but callers never use the result in that case.
   function automatic logic [1:0] f_search(input logic [1:0] start,
                                           input logic [3:0] m);
      logic [1:0] idx;
      logic [1:0] res;
      res = start;
      for (int k = 3; k >= 0; k--) begin
         idx = start + 2'(k);
         if (m[idx]) begin
            res = idx;
         end
      end
      return res;
   endfunction

   // Next-channel decisions; the mask is only consulted here, so changes
   // while a sample is in flight only affect the following search.
   always_comb begin
      w_can_scan  = en && (mask != 4'b0000);
      w_handshake = r_valid && out_ready;
      w_s_inc     = r_s + 2'd1;
      w_pick_ptr  = f_search(r_ptr, mask);
      w_pick_next = f_search(w_s_inc, mask);
      // Bits strictly above the current channel; empty for channel 3.
      w_above     = 4'b1110 << r_s;
      w_last      = ((mask & w_above) == 4'b0000);
   end

   // Scan FSM with registered select, sample, channel, valid and done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_ptr   <= 2'd0;
         r_s     <= 2'd0;
         r_data  <= '0;
         r_ch    <= 2'd0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_can_scan) begin
                  r_s     <= w_pick_ptr;
                  r_state <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               // Select has been stable for a full cycle; capture the mux.
               r_data  <= y;
               r_ch    <= r_s;
               r_valid <= 1'b1;
               r_state <= ST_OUT;
            end
            ST_OUT: begin
               if (w_handshake) begin
                  r_ptr   <= w_s_inc;
                  r_done  <= w_last;
                  r_valid <= 1'b0;
                  if (w_can_scan) begin
                     r_s     <= w_pick_next;
                     r_state <= ST_SETTLE;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign s         = r_s;
   assign out_data  = r_data;
   assign out_ch    = r_ch;
   assign out_valid = r_valid;
   assign scan_done = r_done;
   assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire
